// File: rtl/vga_timing_multi.sv
// vga_timing_multi
// ----------------------------------------------------------------------------
// Multi-mode VGA timing generator at the head of the pixel pipeline.
// It counts pixels and lines for one of three video modes and decodes sync and
// blanking from those counts. A new mode can be requested at any time. The
// request is only applied on the edge that leaves the last pixel of a frame, so
// neither mode ever produces a partial line or a partial frame. The block does
// not change pclk; the pixel clock must already match the selected mode.
//
// Parameters
//   CNT_W        width of hcount/vcount (>= 11)
//   DEFAULT_MODE mode used out of reset (0..2)
//
// Ports
//   pclk         pixel clock
//   rst_n        asynchronous active-low reset
//   mode_sel     requested mode: 0 = 800x600, 1 = 640x480, 2 = 1024x768
//   mode_load    one-cycle strobe; a legal mode_sel becomes the pending request
//   hcount       horizontal pixel counter
//   vcount       vertical line counter
//   hsync/vsync  sync outputs, polarity depends on the mode
//   hblnk/vblnk  blanking, active high
//   frame_start  high while (0,0) is shown after a frame wrap
//   mode_cur     mode currently driving the counters
//   mode_pend    a request is waiting for the frame boundary
// ----------------------------------------------------------------------------
module vga_timing_multi #(
  parameter int         CNT_W        = 12,
  parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [1:0]       mode_sel,
  input  logic             mode_load,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  output logic [1:0]       mode_cur,
  output logic             mode_pend
);

  // Mode 0 uses positive syncs. Modes 1 and 2 use negative syncs.
  localparam logic DEF_NEG = (DEFAULT_MODE != 2'd0);

  function automatic logic [CNT_W-1:0] htot_of(input logic [1:0] m);
    case (m)
      2'd1:    htot_of = CNT_W'(800);
      2'd2:    htot_of = CNT_W'(1344);
      default: htot_of = CNT_W'(1056);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] vtot_of(input logic [1:0] m);
    case (m)
      2'd1:    vtot_of = CNT_W'(525);
      2'd2:    vtot_of = CNT_W'(806);
      default: vtot_of = CNT_W'(628);
    endcase
  endfunction

  // Decodes a count pair for mode m. The result is {hsync, vsync, hblnk, vblnk}.
  function automatic logic [3:0] decode(input logic [1:0]       m,
                                        input logic [CNT_W-1:0] h,
                                        input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] hact, hs0, hs1, vact, vs0, vs1;
    logic             neg;
    case (m)
      2'd1: begin
        hact = CNT_W'(640);  hs0 = CNT_W'(656);  hs1 = CNT_W'(751);
        vact = CNT_W'(480);  vs0 = CNT_W'(490);  vs1 = CNT_W'(491);
        neg  = 1'b1;
      end
      2'd2: begin
        hact = CNT_W'(1024); hs0 = CNT_W'(1048); hs1 = CNT_W'(1183);
        vact = CNT_W'(768);  vs0 = CNT_W'(771);  vs1 = CNT_W'(776);
        neg  = 1'b1;
      end
      default: begin
        hact = CNT_W'(800);  hs0 = CNT_W'(840);  hs1 = CNT_W'(967);
        vact = CNT_W'(600);  vs0 = CNT_W'(601);  vs1 = CNT_W'(604);
        neg  = 1'b0;
      end
    endcase
    decode = {((h >= hs0) && (h <= hs1)) ^ neg,
              ((v >= vs0) && (v <= vs1)) ^ neg,
              (h >= hact),
              (v >= vact)};
  endfunction

  logic [CNT_W-1:0] hcount_reg, hcount_next;
  logic [CNT_W-1:0] vcount_reg, vcount_next;
  logic [1:0]       mode_cur_reg, mode_next;
  logic [1:0]       pend_val_reg, pend_val_next;
  logic             pend_reg, pend_next;
  logic             hsync_reg, vsync_reg, hblnk_reg, vblnk_reg, frame_start_reg;
  logic             h_last, v_last, frame_wrap, load_ok;
  logic [3:0]       dec_next;

  always_comb begin
    h_last      = (hcount_reg == htot_of(mode_cur_reg) - CNT_W'(1));
    v_last      = (vcount_reg == vtot_of(mode_cur_reg) - CNT_W'(1));
    frame_wrap  = h_last && v_last;
    load_ok     = mode_load && (mode_sel != 2'd3);

    hcount_next = h_last ? '0 : hcount_reg + CNT_W'(1);
    vcount_next = vcount_reg;
    if (h_last) begin
      vcount_next = v_last ? '0 : vcount_reg + CNT_W'(1);
    end

    // The wrap applies the request that was pending before this edge. A load
    // in the same cycle only replaces the pending value for the next wrap.
    mode_next     = (frame_wrap && pend_reg) ? pend_val_reg : mode_cur_reg;
    pend_next     = pend_reg;
    pend_val_next = pend_val_reg;
    if (frame_wrap) begin
      pend_next = 1'b0;
    end
    if (load_ok) begin
      pend_next     = 1'b1;
      pend_val_next = mode_sel;
    end

    // The outputs are decoded from the next counts and the next mode. This keeps
    // sync and blanking aligned with the counts shown in the same cycle.
    dec_next = decode(mode_next, hcount_next, vcount_next);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      mode_cur_reg    <= DEFAULT_MODE;
      pend_val_reg    <= DEFAULT_MODE;
      pend_reg        <= 1'b0;
      hsync_reg       <= DEF_NEG;
      vsync_reg       <= DEF_NEG;
      hblnk_reg       <= 1'b0;
      vblnk_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      mode_cur_reg    <= mode_next;
      pend_val_reg    <= pend_val_next;
      pend_reg        <= pend_next;
      hsync_reg       <= dec_next[3];
      vsync_reg       <= dec_next[2];
      hblnk_reg       <= dec_next[1];
      vblnk_reg       <= dec_next[0];
      frame_start_reg <= frame_wrap;
    end
  end

  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign hblnk       = hblnk_reg;
  assign vblnk       = vblnk_reg;
  assign frame_start = frame_start_reg;
  assign mode_cur    = mode_cur_reg;
  assign mode_pend   = pend_reg;

endmodule
